// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core_ctrl tile sequencer: FSM states and the
// bit layout of the 17-bit core instruction bus.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_Q = 3'd1,
        ST_LOAD_K = 3'd2,
        ST_KLOAD  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int INST_W        = 17;
    localparam int ADDR_W        = 4;

    localparam int INST_OFIFO_RD = 16;
    localparam int INST_EXEC     = 7;
    localparam int INST_KLOAD    = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    localparam int QK_ADDR_LSB   = 12;
    localparam int QK_ADDR_MSB   = QK_ADDR_LSB + ADDR_W - 1;
    localparam int P_ADDR_LSB    = 8;
    localparam int P_ADDR_MSB    = P_ADDR_LSB + ADDR_W - 1;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-latency shift register of D stages, W bits wide; D=0 is a plain wire.
// Used to align strobes with SRAM read latency and SFU latency.
module delay_pipe #(
    parameter int D = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (D == 0) begin : g_wire
        assign dout = din;
    end else begin : g_reg
        logic [D-1:0][W-1:0] stage_q;
        logic [D-1:0][W-1:0] stage_d;

        always_comb begin
            stage_d    = stage_q;
            stage_d[0] = din;
            for (int i = 1; i < D; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[D-1];
    end

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer feeding core: loads q/k memories, preloads weights, executes
// activation rows and drains results through the SFU into psum memory.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_Q  | accepting NQ activation beats into qmem
// LOAD_K  | accepting col weight beats into kmem
// KLOAD   | col kmem reads, last kernel-load strobe, one bubble
// EXEC    | NQ qmem reads, then last execute strobe
// DRAIN   | ofifo reads gated by fifo_valid; pmem writes after SFU_LAT
// DONE    | one-cycle done pulse
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int pr      = 8,
    parameter int bw      = 4,
    parameter int col     = 8,
    parameter int NQ      = 8,
    parameter int SFU_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [pr*bw-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               fifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic [pr*bw-1:0]   mem_in,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0] NQ_LAST  = ADDR_W'(NQ - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(col - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [1:0]          tail_q, tail_d;
    logic                rd_all_q, rd_all_d;

    logic q_wr, k_wr, k_rd, q_rd, f_rd;

    logic [1:0]          align_out;
    logic [ADDR_W:0]     pw_out;
    logic                pw_valid;
    logic [ADDR_W-1:0]   pw_addr;

    logic [INST_W-1:0]   inst_q, inst_d;
    logic [pr*bw-1:0]    mem_in_q, mem_in_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Read strobes delayed one cycle to line up with SRAM output data.
    delay_pipe #(.D(1), .W(2)) u_align (
        .clk   (clk),
        .rst_n (reset),
        .din   ({q_rd, k_rd}),
        .dout  (align_out)
    );

    delay_pipe #(.D(SFU_LAT), .W(ADDR_W + 1)) u_pmem_dly (
        .clk   (clk),
        .rst_n (reset),
        .din   ({f_rd, cnt_q}),
        .dout  (pw_out)
    );

    assign pw_valid = pw_out[ADDR_W];
    assign pw_addr  = pw_out[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tail_q   <= '0;
            rd_all_q <= 1'b0;
            inst_q   <= '0;
            mem_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            rd_all_q <= rd_all_d;
            inst_q   <= inst_d;
            mem_in_q <= mem_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        rd_all_d = rd_all_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                tail_d   = '0;
                rd_all_d = 1'b0;
                if (start) state_d = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                if (q_wr) begin
                    if (cnt_q == NQ_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_K;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_LOAD_K: begin
                if (k_wr) begin
                    if (cnt_q == COL_LAST) begin
                        cnt_d   = '0;
                        tail_d  = '0;
                        state_d = ST_KLOAD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_KLOAD: begin
                if (k_rd) begin
                    if (cnt_q == COL_LAST) begin
                        cnt_d  = '0;
                        tail_d = 2'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (tail_q == 2'd1) begin
                    tail_d = 2'd2;
                end else begin
                    tail_d  = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (q_rd) begin
                    if (cnt_q == NQ_LAST) begin
                        cnt_d  = '0;
                        tail_d = 2'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    tail_d   = '0;
                    rd_all_d = 1'b0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (f_rd) begin
                    if (cnt_q == NQ_LAST) rd_all_d = 1'b1;
                    else                  cnt_d    = cnt_q + 4'd1;
                end
                if (pw_valid && (pw_addr == NQ_LAST)) state_d = ST_DONE;
            end
            ST_DONE: begin
                cnt_d    = '0;
                rd_all_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_wr = 1'b0;
        k_wr = 1'b0;
        k_rd = 1'b0;
        q_rd = 1'b0;
        f_rd = 1'b0;
        case (state_q)
            ST_LOAD_Q: q_wr = in_valid;
            ST_LOAD_K: k_wr = in_valid;
            ST_KLOAD:  k_rd = (tail_q == 2'd0);
            ST_EXEC:   q_rd = (tail_q == 2'd0);
            ST_DRAIN:  f_rd = fifo_valid && !rd_all_q;
            default: ;
        endcase
    end

    assign in_ready = (state_q == ST_LOAD_Q) || (state_q == ST_LOAD_K);
    assign busy_d   = (state_d != ST_IDLE);
    assign done_d   = (state_d == ST_DONE);

    always_comb begin
        inst_d                = '0;
        inst_d[INST_QMEM_WR]  = q_wr;
        inst_d[INST_KMEM_WR]  = k_wr;
        inst_d[INST_KMEM_RD]  = k_rd;
        inst_d[INST_QMEM_RD]  = q_rd;
        inst_d[INST_KLOAD]    = align_out[0];
        inst_d[INST_EXEC]     = align_out[1];
        inst_d[INST_OFIFO_RD] = f_rd;
        inst_d[INST_PMEM_RD]  = 1'b0;
        inst_d[INST_PMEM_WR]  = pw_valid;
        if (q_wr || k_wr || k_rd || q_rd) inst_d[QK_ADDR_MSB:QK_ADDR_LSB] = cnt_q;
        if (pw_valid)                     inst_d[P_ADDR_MSB:P_ADDR_LSB]   = pw_addr;
        mem_in_d = (q_wr || k_wr) ? in_data : '0;
    end

    assign inst   = inst_q;
    assign mem_in = mem_in_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: an event-schedule model of one tile,
// randomized in_valid / fifo_valid patterns, reset and start-ignore scenarios.
module tb_core_ctrl;

    localparam int PR   = 8;
    localparam int BW   = 4;
    localparam int COL  = 8;
    localparam int NQ   = 8;
    localparam int LAT  = 1;
    localparam int DW   = PR * BW;
    localparam int MAXC = 256;
    localparam int TMIN = NQ + COL + COL + 2 + NQ + 1 + NQ + LAT + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          fifo_valid = 1'b0;
    logic          in_ready;
    logic [16:0]   inst;
    logic [DW-1:0] mem_in;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    bit            iv [MAXC];
    bit            fv [MAXC];
    logic [DW-1:0] dat [MAXC];
    logic [16:0]   e_inst [MAXC];
    logic [DW-1:0] e_mem [MAXC];
    bit            e_memchk [MAXC];
    bit            e_rdy [MAXC];
    bit            e_busy [MAXC];
    bit            e_done [MAXC];
    int            c_last, c_exec, done_cyc, done_cnt;

    core_ctrl #(.pr(PR), .bw(BW), .col(COL), .NQ(NQ), .SFU_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .mem_in     (mem_in),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected bus activity per cycle; cycle 1 is the first cycle after start is sampled.
    function automatic void build_model();
        int c, n, r, lim, ck;
        for (int i = 0; i < MAXC; i++) begin
            e_inst[i] = '0; e_mem[i] = '0; e_memchk[i] = 0;
            e_rdy[i] = 0; e_busy[i] = 0; e_done[i] = 0;
        end
        c = 1;
        for (int ph = 0; ph < 2; ph++) begin
            n = 0;
            lim = (ph == 0) ? NQ : COL;
            while (n < lim) begin
                e_rdy[c] = 1;
                if (iv[c]) begin
                    e_inst[c+1] = e_inst[c+1] | ((ph == 0) ? 17'h00010 : 17'h00004) | (17'(n) << 12);
                    e_mem[c+1] = dat[c];
                    e_memchk[c+1] = 1;
                    n++;
                end
                c++;
            end
        end
        ck = c;
        for (int i = 0; i < COL; i++) begin
            e_inst[ck+i+1] = e_inst[ck+i+1] | 17'h00008 | (17'(i) << 12);
            e_inst[ck+i+2] = e_inst[ck+i+2] | 17'h00040;
        end
        c_exec = ck + COL + 2;
        for (int i = 0; i < NQ; i++) begin
            e_inst[c_exec+i+1] = e_inst[c_exec+i+1] | 17'h00020 | (17'(i) << 12);
            e_inst[c_exec+i+2] = e_inst[c_exec+i+2] | 17'h00080;
        end
        c = c_exec + NQ + 1;
        r = 0;
        while (r < NQ) begin
            if (fv[c]) begin
                e_inst[c+1]     = e_inst[c+1] | 17'h10000;
                e_inst[c+1+LAT] = e_inst[c+1+LAT] | 17'h00001 | (17'(r) << 8);
                r++;
            end
            c++;
        end
        c_last = c + LAT;
        e_done[c_last] = 1;
        for (int i = 1; i <= c_last; i++) e_busy[i] = 1;
    endfunction

    // mode: 0 all ones, 1 toggle 1,0,..., 2 pattern 1,1,0,0, 3 random (75% high)
    function automatic bit pat(input int mode, input int c);
        if (c >= 150) return 1'b1;
        case (mode)
            0: return 1'b1;
            1: return (c % 2) == 1;
            2: return (c % 4) < 2;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    function automatic void fill(input int iv_mode, input int fv_mode);
        for (int c = 0; c < MAXC; c++) begin
            iv[c]  = pat(iv_mode, c);
            fv[c]  = pat(fv_mode, c);
            dat[c] = DW'($urandom);
        end
        iv[0] = 0;
    endfunction

    task automatic run_tile(input string tag, input bit start_in_drain, input bit start_at_done, input bit rst_exec);
        int rst_cyc, sb_cyc;
        build_model();
        rst_cyc  = rst_exec ? c_exec + 2 : -1;
        sb_cyc   = start_in_drain ? c_last - 1 - LAT : -1;
        done_cyc = -1;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1; in_valid = 0; fifo_valid = 0;
        for (int c = 1; c <= c_last + 1; c++) begin
            @(posedge clk); #1;
            start      = (c == sb_cyc) || (start_at_done && c == c_last);
            in_valid   = iv[c];
            in_data    = dat[c];
            fifo_valid = fv[c];
            if (c == rst_cyc) begin
                #1 reset = 0;
                #1;
                checks++;
                if (inst !== 17'h0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || mem_in !== '0) begin
                    failures++;
                    $display("FAIL %s async_reset inst=%h busy=%b done=%b in_ready=%b mem_in=%h required all zero",
                             tag, inst, busy, done, in_ready, mem_in);
                end
                start = 0; in_valid = 0; fifo_valid = 0;
                repeat (2) @(posedge clk);
                #1 reset = 1;
                return;
            end
            @(negedge clk);
            checks++;
            if (inst !== e_inst[c]) begin
                failures++;
                $display("FAIL %s inst cycle=%0d got=%h expected=%h", tag, c, inst, e_inst[c]);
            end
            checks++;
            if (in_ready !== e_rdy[c]) begin
                failures++;
                $display("FAIL %s in_ready cycle=%0d got=%b expected=%b", tag, c, in_ready, e_rdy[c]);
            end
            checks++;
            if (busy !== e_busy[c]) begin
                failures++;
                $display("FAIL %s busy cycle=%0d got=%b expected=%b", tag, c, busy, e_busy[c]);
            end
            checks++;
            if (done !== e_done[c]) begin
                failures++;
                $display("FAIL %s done cycle=%0d got=%b expected=%b", tag, c, done, e_done[c]);
            end
            if (e_memchk[c]) begin
                checks++;
                if (mem_in !== e_mem[c]) begin
                    failures++;
                    $display("FAIL %s mem_in cycle=%0d got=%h expected=%h", tag, c, mem_in, e_mem[c]);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            start = 0; in_valid = 1'($urandom); fifo_valid = 1'($urandom);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || inst !== 17'h0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s idle_after busy=%b done=%b inst=%h in_ready=%b required 0",
                         tag, busy, done, inst, in_ready);
                if (done === 1'b1) done_cnt++;
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d required=1", tag, done_cnt);
        end
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #1;
        checks++;
        if (inst !== 17'h0 || mem_in !== '0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_async inst=%h mem_in=%h busy=%b done=%b in_ready=%b required 0",
                     inst, mem_in, busy, done, in_ready);
        end
        start = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || inst !== 17'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_held busy=%b inst=%h in_ready=%b required 0", busy, inst, in_ready);
        end
        @(posedge clk); #1;
        start = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b required 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        fill(0, 0);
        run_tile("back_to_back", 0, 0, 0);
        checks++;
        if (done_cyc !== TMIN) begin
            failures++;
            $display("FAIL tile_length done_cycle got=%0d required=%0d", done_cyc, TMIN);
        end
    endtask

    task automatic test_valid_toggle();
        fill(1, 0);
        run_tile("valid_toggle", 0, 0, 0);
    endtask

    task automatic test_drain_pattern();
        fill(0, 2);
        run_tile("drain_pattern", 0, 0, 0);
    endtask

    task automatic test_start_ignored();
        fill(3, 3);
        run_tile("start_ignored", 1, 1, 0);
    endtask

    task automatic test_reset_mid_exec();
        fill(3, 3);
        run_tile("reset_mid_exec", 0, 0, 1);
        fill(3, 3);
        run_tile("after_reset", 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            fill(3, 3);
            run_tile("random", 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_drain_pattern();
        test_start_ignored();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
